// File: rtl/control_unit_if.sv
// Handshake/bus bundle between the instruction source and the control_unit
// timestep sequencer. The master drives EXEC/INSTR; the slave drives the strobes.
interface control_unit_if #(
  parameter int IW   = 10,
  parameter int RSEL = 2
);
  localparam int NREG = 2 ** RSEL;

  logic            EXEC;
  logic [IW-1:0]   INSTR;
  logic            IRin;
  logic            EXTRN;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic            ADDSUB;
  logic [1:0]      TIME;
  logic            DONE;
  logic            BUSY;

  modport master (
    output EXEC, INSTR,
    input  IRin, EXTRN, Rout, Rin, Ain, Gin, Gout, ADDSUB, TIME, DONE, BUSY
  );

  modport slave (
    input  EXEC, INSTR,
    output IRin, EXTRN, Rout, Rin, Ain, Gin, Gout, ADDSUB, TIME, DONE, BUSY
  );
endinterface

// File: rtl/control_unit.sv
// Timestep sequencer (T0..T3) for the shared-bus register datapath.
// Optional macro DONE_HOLD_EN: DONE becomes a register held through idle.
//
// state | meaning
// T0    | idle; capture instruction on EXEC rising edge
// T1    | LOAD/MOV complete here; ADD/SUB move Rx into A
// T2    | Ry onto bus, ALU result into G
// T3    | G written back into Rx
module control_unit #(
  parameter int IW   = 10,
  parameter int RSEL = 2
) (
  input logic           CLK,
  input logic           CLRb,
  control_unit_if.slave bus
);
  localparam int NREG = 2 ** RSEL;
  localparam int FW   = 2 + 2 * RSEL;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   ir;
  logic            exec_q;
  logic            start;
  logic            done_step;
  logic [1:0]      opcode;
  logic [RSEL-1:0] rx, ry;
  logic [NREG-1:0] rx_hot, ry_hot;
  logic            unused_instr;

  // Only opcode/Rx/Ry are ever decoded; the low instruction bits are don't-care.
  assign unused_instr = ^bus.INSTR[IW-FW-1:0];

  assign start  = bus.EXEC & ~exec_q;
  assign opcode = ir[FW-1 -: 2];
  assign rx     = ir[2*RSEL-1 -: RSEL];
  assign ry     = ir[RSEL-1:0];
  assign rx_hot = NREG'(1) << rx;
  assign ry_hot = NREG'(1) << ry;

  always_ff @(posedge CLK) begin
    if (!CLRb) begin
      state  <= T0;
      ir     <= '0;
      exec_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      exec_q <= bus.EXEC;
      if (state == T0 && start) ir <= bus.INSTR[IW-1 -: FW];
    end
  end

  always_comb begin
    state_nxt  = state;
    done_step  = 1'b0;
    bus.IRin   = 1'b0;
    bus.EXTRN  = 1'b0;
    bus.Rout   = '0;
    bus.Rin    = '0;
    bus.Ain    = 1'b0;
    bus.Gin    = 1'b0;
    bus.Gout   = 1'b0;
    bus.ADDSUB = 1'b0;
    case (state)
      T0: begin
        bus.IRin = start;
        if (start) state_nxt = T1;
      end
      T1: begin
        case (opcode)
          2'b00: begin
            bus.EXTRN = 1'b1;
            bus.Rin   = rx_hot;
            done_step = 1'b1;
            state_nxt = T0;
          end
          2'b01: begin
            bus.Rout  = ry_hot;
            bus.Rin   = rx_hot;
            done_step = 1'b1;
            state_nxt = T0;
          end
          default: begin
            bus.Rout  = rx_hot;
            bus.Ain   = 1'b1;
            state_nxt = T2;
          end
        endcase
      end
      T2: begin
        bus.Rout   = ry_hot;
        bus.Gin    = 1'b1;
        bus.ADDSUB = opcode[0];
        state_nxt  = T3;
      end
      T3: begin
        bus.Gout  = 1'b1;
        bus.Rin   = rx_hot;
        done_step = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

  assign bus.TIME = state;
  assign bus.BUSY = (state != T0);

`ifdef DONE_HOLD_EN
  logic done_q;

  // Set by the final step, held through idle, cleared when the next start is taken.
  always_ff @(posedge CLK) begin
    if (!CLRb)                    done_q <= 1'b0;
    else if (state == T0 && start) done_q <= 1'b0;
    else if (done_step)           done_q <= 1'b1;
  end

  assign bus.DONE = done_q;
`else
  assign bus.DONE = done_step;
`endif
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-instruction step-schedule model
// compared every cycle, plus literal expectations from hand-worked sequences.
module tb_control_unit;
  localparam int IW = 10, RSEL = 2, NREG = 4;

  logic CLK = 1'b0;
  logic CLRb = 1'b0;
  always #5 CLK = ~CLK;

  control_unit_if #(.IW(IW), .RSEL(RSEL)) cu_if ();
  control_unit #(.IW(IW), .RSEL(RSEL)) dut (.CLK(CLK), .CLRb(CLRb), .bus(cu_if.slave));

  typedef struct packed {
    logic       irin;
    logic       extrn;
    logic [3:0] rout;
    logic [3:0] rin;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       addsub;
    logic [1:0] tm;
    logic       done;
    logic       busy;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  bit   check_en = 1'b0;
  vec_t exp_q[$];
  logic prev_exec = 1'b0;
  logic done_latched = 1'b0;
  vec_t popped;

  // Expected output schedule of one instruction, one entry per step after T0.
  function automatic void push_instr(input logic [IW-1:0] i);
    logic [1:0] op;
    logic [3:0] x, y;
    vec_t v;
    op = i[9:8];
    x  = 4'b0001 << i[7:6];
    y  = 4'b0001 << i[5:4];
    v = '0; v.busy = 1'b1; v.tm = 2'd1;
    if (op == 2'b00) begin
      v.extrn = 1'b1; v.rin = x; v.done = 1'b1; exp_q.push_back(v);
    end else if (op == 2'b01) begin
      v.rout = y; v.rin = x; v.done = 1'b1; exp_q.push_back(v);
    end else begin
      v.rout = x; v.ain = 1'b1; exp_q.push_back(v);
      v = '0; v.busy = 1'b1; v.tm = 2'd2; v.rout = y; v.gin = 1'b1; v.addsub = op[0];
      exp_q.push_back(v);
      v = '0; v.busy = 1'b1; v.tm = 2'd3; v.gout = 1'b1; v.rin = x; v.done = 1'b1;
      exp_q.push_back(v);
    end
  endfunction

  always @(posedge CLK) begin
    if (!CLRb) begin
      exp_q.delete();
      prev_exec    = 1'b0;
      done_latched = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        if (popped.done) done_latched = 1'b1;
      end else if (cu_if.EXEC && !prev_exec) begin
        done_latched = 1'b0;
        push_instr(cu_if.INSTR);
      end
      prev_exec = cu_if.EXEC;
    end
  end

  function automatic vec_t expected_now();
    vec_t e;
    if (exp_q.size() > 0) e = exp_q[0];
    else begin
      e = '0;
      e.irin = cu_if.EXEC & ~prev_exec;
    end
`ifdef DONE_HOLD_EN
    e.done = done_latched;
`endif
    return e;
  endfunction

  always @(negedge CLK) begin
    vec_t a, e;
    int drivers;
    if (check_en) begin
      a = '{cu_if.IRin, cu_if.EXTRN, cu_if.Rout, cu_if.Rin, cu_if.Ain, cu_if.Gin,
            cu_if.Gout, cu_if.ADDSUB, cu_if.TIME, cu_if.DONE, cu_if.BUSY};
      e = expected_now();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, a, e);
      end
      drivers = $countones({cu_if.EXTRN, cu_if.Rout, cu_if.Gout});
      checks++;
      if (drivers > 1) begin
        errors++;
        $display("FAIL bus_exclusive t=%0t drivers=%0d expected<=1", $time, drivers);
      end
    end
  end

  task automatic lit(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    cu_if.EXEC  = 1'b0;
    cu_if.INSTR = '0;
    CLRb = 1'b0;
    step(); step();
    CLRb = 1'b1;
    check_en = 1'b1;
    @(negedge CLK);
    lit("reset_time", cu_if.TIME, 0);
    lit("reset_busy", cu_if.BUSY, 0);

    // LOAD R1
    step(); cu_if.INSTR = 10'b00_01_00_0000;
    step(); cu_if.EXEC = 1'b1;
    @(negedge CLK);
    lit("load_irin", cu_if.IRin, 1);
    lit("load_t0_time", cu_if.TIME, 0);
    step(); @(negedge CLK);
    lit("load_t1_time", cu_if.TIME, 1);
    lit("load_extrn", cu_if.EXTRN, 1);
    lit("load_rin", cu_if.Rin, 4'b0010);
`ifndef DONE_HOLD_EN
    lit("load_done", cu_if.DONE, 1);
`endif
    step(); @(negedge CLK);
    lit("load_back_t0", cu_if.TIME, 0);
`ifdef DONE_HOLD_EN
    lit("hold_done_idle0", cu_if.DONE, 1);
    step(); step(); @(negedge CLK);
    lit("hold_done_idle2", cu_if.DONE, 1);
`endif

    // MOV R3,R0
    step(); cu_if.EXEC = 1'b0; cu_if.INSTR = 10'b01_11_00_0000;
    step(); cu_if.EXEC = 1'b1;
    step(); @(negedge CLK);
    lit("mov_rout", cu_if.Rout, 4'b0001);
    lit("mov_rin", cu_if.Rin, 4'b1000);
`ifdef DONE_HOLD_EN
    lit("hold_done_cleared", cu_if.DONE, 0);
`else
    lit("mov_done", cu_if.DONE, 1);
`endif
    step(); @(negedge CLK);
    lit("mov_two_cycles", cu_if.BUSY, 0);

    // SUB R2,R1
    step(); cu_if.EXEC = 1'b0; cu_if.INSTR = 10'b11_10_01_0000;
    step(); cu_if.EXEC = 1'b1;
    step(); @(negedge CLK);
    lit("sub_t1_rout", cu_if.Rout, 4'b0100);
    lit("sub_t1_ain", cu_if.Ain, 1);
    step(); @(negedge CLK);
    lit("sub_t2_rout", cu_if.Rout, 4'b0010);
    lit("sub_t2_addsub", cu_if.ADDSUB, 1);
    step(); @(negedge CLK);
    lit("sub_t3_gout", cu_if.Gout, 1);
    lit("sub_t3_rin", cu_if.Rin, 4'b0100);
    step(); @(negedge CLK);
    lit("sub_end_time", cu_if.TIME, 0);

    // ADD R0,R3 with EXEC toggled and INSTR changed while busy; EXEC then held high
    step(); cu_if.EXEC = 1'b0; cu_if.INSTR = 10'b10_00_11_0000;
    step(); cu_if.EXEC = 1'b1;
    step(); cu_if.EXEC = 1'b0;
    step(); cu_if.EXEC = 1'b1; cu_if.INSTR = 10'b00_10_00_0000;
    @(negedge CLK);
    lit("add_t2_rout", cu_if.Rout, 4'b1000);
    lit("add_t2_addsub", cu_if.ADDSUB, 0);
    step(); @(negedge CLK);
    lit("add_t3_rin_unchanged", cu_if.Rin, 4'b0001);
    step(); step(); step(); @(negedge CLK);
    lit("held_exec_no_restart", cu_if.BUSY, 0);

    // Reset during T2 of ADD R1,R1
    step(); cu_if.EXEC = 1'b0; cu_if.INSTR = 10'b10_01_01_0000;
    step(); cu_if.EXEC = 1'b1;
    step(); step(); cu_if.EXEC = 1'b0;
    @(negedge CLK);
    lit("rr_t2_rout", cu_if.Rout, 4'b0010);
    CLRb = 1'b0;
    step(); step();
    CLRb = 1'b1;
    @(negedge CLK);
    lit("mid_reset_time", cu_if.TIME, 0);
    lit("mid_reset_rin", cu_if.Rin, 0);
    lit("mid_reset_done", cu_if.DONE, 0);
    step(); @(negedge CLK);
    lit("mid_reset_no_wb", cu_if.Rin, 0);

    // Random stream; model and bus-exclusivity checked every cycle
    for (int n = 0; n < 400; n++) begin
      step();
      cu_if.EXEC  = 1'($urandom_range(0, 1));
      cu_if.INSTR = 10'($urandom);
      CLRb = ($urandom_range(0, 60) != 0);
    end
    step(); CLRb = 1'b1; cu_if.EXEC = 1'b0;
    step(); step(); step(); step();
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Timestep sequencer for the 10-bit bus datapath: four registers, accumulator A, ALU result register G, external data source, one shared bus.
- Latches an instruction word on an EXEC rising edge and steps T0..T3.
- Per step, drives exactly one bus source and the required load enables.
- Exports TIME and DONE for the display/output logic.

Parameters:
IW, 10, instruction width; opcode = IR[IW-1:IW-2], Rx = next RSEL bits, Ry = next RSEL bits below that
RSEL, 2, register-select width; register count NREG = 2**RSEL

Ports:
CLK  in  1  clock, rising edge
CLRb  in  1  synchronous active-low reset
EXEC  in  1  execute request (level, already synchronised); acted on at rising edge only
INSTR  in  IW  instruction word
IRin  out  1  IR load strobe; asserted in the cycle INSTR is captured
EXTRN  out  1  drive external data onto bus
Rout  out  NREG  one-hot register bus-drive enables
Rin  out  NREG  one-hot register load enables
Ain  out  1  load A from bus
Gin  out  1  load G with ALU result
Gout  out  1  drive G onto bus
ADDSUB  out  1  ALU op: 0 = add, 1 = subtract
TIME  out  2  current timestep, 0..3
DONE  out  1  instruction-complete indicator
BUSY  out  1  high in T1..T3

Behaviour:
- Sampling:
  - All state updates on the CLK rising edge.
  - CLRb low at an edge: state = T0, IR = 0, EXEC_q = 0.
  - Reset overrides everything, including mid-instruction. Next cycle shows TIME = 0, all strobes 0, DONE = 0, BUSY = 0, and no partial writeback occurs after reset.
- Start condition:
  - start = EXEC & ~EXEC_q; EXEC_q registers EXEC every cycle.
  - A start while BUSY is ignored: not queued, IR unchanged.
- Opcodes: 00 LOAD, 01 MOV, 10 ADD, 11 SUB.
- State T0 (idle):
  - All strobes 0, except IRin = start.
  - On start: IR <= INSTR, next = T1.
- State T1:
  - LOAD: EXTRN = 1, Rin[Rx] = 1, DONE = 1; next = T0.
  - MOV: Rout[Ry] = 1, Rin[Rx] = 1, DONE = 1; next = T0.
  - ADD/SUB: Rout[Rx] = 1, Ain = 1; next = T2.
- State T2: Rout[Ry] = 1, Gin = 1, ADDSUB = IR opcode bit0; next = T3.
- State T3: Gout = 1, Rin[Rx] = 1, DONE = 1; next = T0.
- Control outputs:
  - Combinational from state and IR (Moore per step).
  - At most one bus driver (EXTRN, any Rout bit, Gout) active in any cycle.
- TIME and BUSY:
  - TIME = state encoding: T0 = 0, T1 = 1, T2 = 2, T3 = 3.
  - BUSY = (state != T0).
- Latency: LOAD/MOV use 2 cycles including the T0 capture; ADD/SUB use 4.
- Back-to-back execution: a new start is accepted in the T0 cycle immediately following the DONE cycle.
- Edge cases:
  - Rx == Ry is legal. MOV Rx,Rx rewrites the same value; ADD Rx,Rx asserts Rout[Rx] in T1 and again in T2.
  - INSTR changes after capture have no effect on the running instruction.

Optional Feature:
- Macro DONE_HOLD_EN.
- Defined: DONE is a register.
  - Set at the edge ending the final step of an instruction (T1 for LOAD/MOV, T3 for ADD/SUB).
  - Held high through idle T0.
  - Cleared on the next accepted start or on reset.
  - Lets the display dot stay lit.
- Undefined: DONE is a combinational one-cycle pulse in the final step, as above.

Test Plan:
- Reset: CLRb = 0 for 2 cycles while in T2 of an ADD -> next cycle TIME = 0, BUSY = 0, all strobes 0, no Rin pulse observed.
- LOAD: INSTR = 10'b00_01_00_0000, EXEC 0->1 -> IRin = 1 at TIME = 0, then TIME = 1 with EXTRN = 1, Rin = 4'b0010, DONE = 1, then TIME = 0.
- MOV: INSTR = 10'b01_11_00_0000 -> T1: Rout = 4'b0001, Rin = 4'b1000, DONE = 1, total 2 cycles.
- SUB: INSTR = 10'b11_10_01_0000:
  - T1: Rout = 0100, Ain = 1.
  - T2: Rout = 0010, Gin = 1, ADDSUB = 1.
  - T3: Gout = 1, Rin = 0100, DONE = 1.
  - Then TIME = 0.
- Busy ignore / edge-only: during an ADD, toggle EXEC 0->1->0 and change INSTR in T2 -> sequence and IR unaffected. Holding EXEC high after completion does not restart.
- Bus exclusivity and DONE hold: random instruction stream with assertion that popcount(EXTRN, Rout, Gout) ≤ 1 every cycle. With DONE_HOLD_EN, DONE stays 1 in idle until the next start, then drops in that cycle's following edge.
